gcd_engine: RTL

- Parametrised successor to the 10-bit GCD top: one module holding control FSM plus datapath.
- Computes gcd(in_a, in_b) for WIDTH-bit unsigned operands.
- Compile-time choice of subtractive (Euclid) or binary (Stein) algorithm.
- Adds a busy/done handshake, zero-operand handling, an error flag and an iteration counter for performance checks.

---
 rtl/gcd_engine.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/gcd_engine.sv
// GCD engine: control FSM and datapath for WIDTH-bit unsigned operands.
// MODE 0 uses repeated subtraction (Euclid); MODE 1 uses binary shift/subtract (Stein).
module gcd_engine #(
    parameter int WIDTH = 10,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             zero_err,
    output logic [CNT_W-1:0] cycles
);

    localparam int K_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_err_q, zero_err_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic             any_zero;
    logic             both_zero;
    logic             ab_equal;
    logic [CNT_W-1:0] cnt_inc;

    assign any_zero  = (in_a == '0) || (in_b == '0);
    assign both_zero = (in_a == '0) && (in_b == '0);
    assign ab_equal  = (a_q == b_q);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            res_q      <= '0;
            zero_err_q <= 1'b0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            zero_err_q <= zero_err_d;
            cycles_q   <= cycles_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = any_zero ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (ab_equal) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: result, error flag and cycle count only move on entry to DONE.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        zero_err_d = zero_err_q;
        cycles_d   = cycles_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    k_d   = '0;
                    cnt_d = '0;
                    if (any_zero) begin
                        res_d      = in_a | in_b;
                        zero_err_d = both_zero;
                        cycles_d   = '0;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_inc;
                if (ab_equal) begin
                    res_d      = (MODE == 1) ? (a_q << k_q) : a_q;
                    zero_err_d = 1'b0;
                    cycles_d   = cnt_inc;
                end else if (MODE == 1) begin
                    if (!a_q[0] && !b_q[0]) begin
                        a_d = a_q >> 1;
                        b_d = b_q >> 1;
                        k_d = k_q + 1'b1;
                    end else if (!a_q[0]) begin
                        a_d = a_q >> 1;
                    end else if (!b_q[0]) begin
                        b_d = b_q >> 1;
                    end else if (a_q > b_q) begin
                        a_d = a_q - b_q;
                    end else begin
                        b_d = b_q - a_q;
                    end
                end else begin
                    if (a_q > b_q) a_d = a_q - b_q;
                    else           b_d = b_q - a_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        res      = res_q;
        zero_err = zero_err_q;
        cycles   = cycles_q;
    end

endmodule
